// File: rtl/sfq_drv_pkg.sv
// Shared types and constants for the RSFQ gate driver.
// Build option: SFQ_DRV_SYNC_EN adds a 2-flop synchronizer on sfq_q and
// stretches the q observation window by SYNC_EXTRA cycles.
package sfq_drv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PA    = 3'd1,
        GAP   = 3'd2,
        PB    = 3'd3,
        SETUP = 3'd4,
        CK    = 3'd5,
        WIN   = 3'd6,
        DONE  = 3'd7
    } state_t;

`ifdef SFQ_DRV_SYNC_EN
    localparam int SYNC_EXTRA = 2;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    // q edge counter saturates here: two or more edges is an error
    localparam logic [1:0] QCNT_SAT = 2'd2;

    // Final counter value of a timed state; a length of 0 still lasts one cycle
    function automatic int last_cnt(input int cyc);
        return (cyc == 0) ? 0 : cyc - 1;
    endfunction

endpackage

// File: rtl/sfq_toggle_det.sv
// Sampling flop(s) plus XOR change detector for the toggle-encoded q line.
// Build option: SFQ_DRV_SYNC_EN selects a 2-flop synchronizer instead of a
// single sampling flop. edge_pulse is high for one cycle per level change.
module sfq_toggle_det
    import sfq_drv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sfq_q,
    output logic edge_pulse
);

`ifdef SFQ_DRV_SYNC_EN
    logic [1:0] sync_r;
    logic       last_r;

    // Two-stage synchronizer followed by a history flop for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
            last_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], sfq_q};
            last_r <= sync_r[1];
        end
    end

    assign edge_pulse = sync_r[1] ^ last_r;
`else
    logic samp_r;
    logic last_r;

    // Single sampling flop followed by a history flop for change detection
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_r <= 1'b0;
            last_r <= 1'b0;
        end else begin
            samp_r <= sfq_q;
            last_r <= samp_r;
        end
    end

    assign edge_pulse = samp_r ^ last_r;
`endif

endmodule

// File: rtl/sfq_gate_driver.sv
// Clocked front end for one clocked two-input RSFQ gate (XNORT class).
// Accepts (a, b) requests, emits toggle-encoded pulses on sfq_a/sfq_b/sfq_clk,
// then counts q edges in a window after the clock pulse and reports the result.
// Build option: SFQ_DRV_SYNC_EN (synchronized q input, window longer by 2).
module sfq_gate_driver
    import sfq_drv_pkg::*;
#(
    parameter int AB_GAP_CYC = 2,
    parameter int SETUP_CYC  = 4,
    parameter int Q_WIN_CYC  = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_a,
    input  logic in_b,
    output logic sfq_a,
    output logic sfq_b,
    output logic sfq_clk,
    input  logic sfq_q,
    output logic out_valid,
    input  logic out_ready,
    output logic out_q,
    output logic out_err
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(last_cnt(AB_GAP_CYC));
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(last_cnt(SETUP_CYC));
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(last_cnt(Q_WIN_CYC + SYNC_EXTRA));

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             a_r;
    logic             b_r;
    logic [1:0]       qcnt_r;
    logic [1:0]       qcnt_nxt_s;
    logic             edge_s;

    sfq_toggle_det u_det (
        .clk        (clk),
        .rst        (rst),
        .sfq_q      (sfq_q),
        .edge_pulse (edge_s)
    );

    // Saturating q edge count including this cycle's edge
    always_comb begin
        qcnt_nxt_s = qcnt_r;
        if (edge_s && (qcnt_r != QCNT_SAT)) begin
            qcnt_nxt_s = qcnt_r + 2'd1;
        end else begin
            qcnt_nxt_s = qcnt_r;
        end
    end

    // Operation sequencer: pulse ordering, timing, q window and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            a_r       <= 1'b0;
            b_r       <= 1'b0;
            qcnt_r    <= 2'd0;
            in_ready  <= 1'b0;
            sfq_a     <= 1'b0;
            sfq_b     <= 1'b0;
            sfq_clk   <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= in_a;
                        b_r      <= in_b;
                        in_ready <= 1'b0;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= PA;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                PA: begin
                    if (a_r) begin
                        sfq_a <= ~sfq_a;
                    end
                    cnt_r <= CNT_ZERO;
                    if (a_r && b_r) begin
                        state_r <= GAP;
                    end else begin
                        state_r <= PB;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= PB;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                PB: begin
                    if (b_r) begin
                        sfq_b <= ~sfq_b;
                    end
                    cnt_r   <= CNT_ZERO;
                    state_r <= SETUP;
                end
                SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= CK;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                CK: begin
                    // Edges seen before the clock pulse belong to no operation
                    sfq_clk <= ~sfq_clk;
                    qcnt_r  <= 2'd0;
                    cnt_r   <= CNT_ZERO;
                    state_r <= WIN;
                end
                WIN: begin
                    qcnt_r <= qcnt_nxt_s;
                    if (cnt_r == WIN_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        out_valid <= 1'b1;
                        out_q     <= (qcnt_nxt_s == 2'd1);
                        out_err   <= (qcnt_nxt_s == QCNT_SAT);
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    // Result is frozen here; late q edges are ignored
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_q     <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfq_gate_driver.sv
// Self-checking bench for sfq_gate_driver with a behavioural XNORT gate model
// and a scoreboard of expected results pushed at request acceptance.
module tb_sfq_gate_driver;

    localparam int G = 2;
    localparam int S = 4;
    localparam int W = 8;
`ifdef SFQ_DRV_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT_BASE = 3 + S + W + EXTRA;
    localparam int LAT_AB   = LAT_BASE + G;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_a, in_b, out_ready;
    logic in_ready, sfq_a, sfq_b, sfq_clk, out_valid, out_q, out_err;
    logic sfq_q = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic q;
        logic err;
        int   lat;
        int   acc;
    } exp_t;
    exp_t sb[$];

    sfq_gate_driver #(
        .AB_GAP_CYC (G),
        .SETUP_CYC  (S),
        .Q_WIN_CYC  (W),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .sfq_a     (sfq_a),
        .sfq_b     (sfq_b),
        .sfq_clk   (sfq_clk),
        .sfq_q     (sfq_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- XNORT gate model ----------------
    logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0, g_st = 1'b0;
    int   a_cnt = 0, b_cnt = 0, c_cnt = 0, a_t = 0, b_t = 0, c_t = 0;
    int   qd1 = 0, qd2 = 0;
    logic err_mode = 1'b0;
    int   poke_req = 0, poke_done = 0;

    wire a_ev = (sfq_a !== a_prev);
    wire b_ev = (sfq_b !== b_prev);
    wire c_ev = (sfq_clk !== c_prev);
    wire t1   = (qd1 == 1);
    wire t2   = (qd2 == 1);
    wire pk   = (poke_req != poke_done);

    always @(negedge clk) begin
        poke_done <= poke_req;
        if (rst) begin
            a_prev <= sfq_a;
            b_prev <= sfq_b;
            c_prev <= sfq_clk;
            g_st   <= 1'b0;
            qd1    <= 0;
            qd2    <= 0;
        end else begin
            if (a_ev) begin
                a_prev <= sfq_a;
                a_cnt  <= a_cnt + 1;
                a_t    <= cyc;
            end
            if (b_ev) begin
                b_prev <= sfq_b;
                b_cnt  <= b_cnt + 1;
                b_t    <= cyc;
            end
            if (c_ev) begin
                c_prev <= sfq_clk;
                c_cnt  <= c_cnt + 1;
                c_t    <= cyc;
                g_st   <= 1'b0;
                if (err_mode) begin
                    qd1 <= 1;
                    qd2 <= 4;
                end else if ((g_st ^ a_ev ^ b_ev) == 1'b0) begin
                    qd1 <= 1;
                end
            end else begin
                g_st <= g_st ^ a_ev ^ b_ev;
            end
            if (qd1 != 0) qd1 <= qd1 - 1;
            if (qd2 != 0) qd2 <= qd2 - 1;
            sfq_q <= sfq_q ^ t1 ^ t2 ^ pk;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic a, input logic b, input logic eq,
                             input logic ee, input int lat, input bit push);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1);
        e.q = eq; e.err = ee; e.lat = lat; e.acc = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_low_after_accept", in_ready, 0);
    endtask

    task automatic collect(input int hold);
        int   n;
        int   seen;
        exp_t e;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", out_valid, 1);
        seen = cyc;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", seen - e.acc - 1, e.lat);
            for (int i = 0; i < hold; i++) begin
                if (i == 3) poke_req = poke_req + 1;
                @(negedge clk);
                check("hold_in_ready", in_ready, 0);
                check("hold_out_valid", out_valid, 1);
                check("hold_out_q", out_q, e.q);
            end
            check("out_q", out_q, e.q);
            check("out_err", out_err, e.err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, b0, c0;
        rst = 1'b1; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {in_ready, sfq_a, sfq_b, sfq_clk, out_valid, out_q, out_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        // a only: gate left in state1, no q edge
        a0 = a_cnt; b0 = b_cnt; c0 = c_cnt;
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, LAT_BASE, 1'b1);
        collect(0);
        check("a_only_a_edges", a_cnt - a0, 1);
        check("a_only_b_edges", b_cnt - b0, 0);
        check("a_only_clk_edges", c_cnt - c0, 1);

        // a and b: a first, b after the gap, clock after setup
        drive_req(1'b1, 1'b1, 1'b1, 1'b0, LAT_AB, 1'b1);
        collect(0);
        check("ab_gap", b_t - a_t, G + 1);
        check("b_to_clk", c_t - b_t, S + 1);

        // neither: clock pulse only
        a0 = a_cnt; b0 = b_cnt; c0 = c_cnt;
        drive_req(1'b0, 1'b0, 1'b1, 1'b0, LAT_BASE, 1'b1);
        collect(0);
        check("none_a_edges", a_cnt - a0, 0);
        check("none_b_edges", b_cnt - b0, 0);
        check("none_clk_edges", c_cnt - c0, 1);

        // two q edges inside the window
        err_mode = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, 1'b1, LAT_BASE, 1'b1);
        collect(0);
        err_mode = 1'b0;

        // backpressure in DONE with a waiting request and a stray q edge
        drive_req(1'b0, 1'b0, 1'b1, 1'b0, LAT_BASE, 1'b1);
        in_valid = 1'b1; in_a = 1'b0; in_b = 1'b1;
        collect(10);
        check("ready_after_done", in_ready, 1);
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, LAT_BASE, 1'b1);
        collect(0);

        // reset in SETUP while sfq_a is high
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, LAT_BASE, 1'b0);
        repeat (2) @(negedge clk);
        check("pre_reset_sfq_a", sfq_a, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midop_reset_outputs", {in_ready, sfq_a, sfq_b, sfq_clk, out_valid, out_q, out_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", in_ready, 1);

        // normal operation after the gate model is re-initialised
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, LAT_BASE, 1'b1);
        collect(0);
        drive_req(1'b0, 1'b0, 1'b1, 1'b0, LAT_BASE, 1'b1);
        collect(0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
